// File: rtl/emu_uart_port_arbiter_if.sv
// Console-port bundle between the SoC requesters, the emulated UART and emu_uart_port_arbiter.
// slave = arbiter side, master = requesters/UART/consumer side.
interface emu_uart_port_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]         req_valid;
    logic [8*NREQ-1:0]       req_ch;
    logic [NREQ-1:0]         req_ready;
    logic [$clog2(NREQ)-1:0] grant_id;
    logic                    tx_valid;
    logic [7:0]              tx_ch;
    logic                    rx_valid;
    logic [7:0]              rx_ch;
    logic                    rxq_valid;
    logic [7:0]              rxq_ch;
    logic                    rxq_ready;
    logic                    rx_overflow;

    modport slave (
        input  req_valid, req_ch, rx_valid, rx_ch, rxq_ready,
        output req_ready, grant_id, tx_valid, tx_ch, rxq_valid, rxq_ch, rx_overflow
    );

    modport master (
        output req_valid, req_ch, rx_valid, rx_ch, rxq_ready,
        input  req_ready, grant_id, tx_valid, tx_ch, rxq_valid, rxq_ch, rx_overflow
    );
endinterface

// File: rtl/emu_uart_port_arbiter.sv
// Shares one emulated UART between NREQ console masters: round-robin paced TX plus RX FIFO.
// Optional EMU_UART_LINE_LOCK_EN keeps the grant with one master until it sends 8'h0A.
//
// state | meaning
// IDLE  | round-robin pick among valid requesters, accept one byte
// GAP   | strobe latched byte on first cycle, then TX_GAP idle cycles
// HOLD  | line locked to grant_id until newline byte or LOCK_TIMEOUT idle cycles
module emu_uart_port_arbiter #(
    parameter int NREQ         = 4,
    parameter int TX_GAP       = 0,
    parameter int LOCK_TIMEOUT = 64,
    parameter int RX_DEPTH     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    emu_uart_port_arbiter_if.slave port_if
);
    localparam int GW = $clog2(NREQ);
    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [GW:0]   NREQ_W   = (GW+1)'(NREQ);
    localparam logic [GW-1:0] LAST_ID  = GW'(NREQ - 1);
    localparam logic [7:0]    GAP_INIT = 8'(TX_GAP);

    if (NREQ < 2 || NREQ > 8 || TX_GAP < 0 || TX_GAP > 255 || LOCK_TIMEOUT < 1 ||
        RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_param_check
        $error("emu_uart_port_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, GAP, HOLD} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [7:0]      tx_ch_q, tx_ch_d;
    logic [7:0]      gap_q, gap_d;
    logic            tx_valid_q, tx_valid_d;
    logic [NREQ-1:0] req_ready;
    logic [GW-1:0]   next_ptr;
    logic [GW-1:0]   pick_id;
    logic            pick_found;
    logic [GW:0]     cand;

`ifdef EMU_UART_LINE_LOCK_EN
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    assign next_ptr = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;

    // Scan from the farthest offset down so the closest valid requester at/after ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (GW+1)'(k);
            if (cand >= NREQ_W) cand = cand - NREQ_W;
            if (port_if.req_valid[cand[GW-1:0]]) begin
                pick_found = 1'b1;
                pick_id    = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        tx_ch_d    = tx_ch_q;
        gap_d      = gap_q;
        tx_valid_d = 1'b0;
        req_ready  = '0;
`ifdef EMU_UART_LINE_LOCK_EN
        tmo_d      = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    req_ready[pick_id] = 1'b1;
                    tx_ch_d    = port_if.req_ch[{pick_id, 3'b000} +: 8];
                    grant_d    = pick_id;
                    tx_valid_d = 1'b1;
                    gap_d      = GAP_INIT;
                    state_d    = GAP;
                end
            end
            GAP: begin
                if (gap_q != 8'd0) begin
                    gap_d = gap_q - 8'd1;
                end else begin
`ifdef EMU_UART_LINE_LOCK_EN
                    if (tx_ch_q != 8'h0A) begin
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                        ptr_d   = next_ptr;
                    end
`else
                    state_d = IDLE;
                    ptr_d   = next_ptr;
`endif
                end
            end
`ifdef EMU_UART_LINE_LOCK_EN
            HOLD: begin
                if (port_if.req_valid[grant_q]) begin
                    req_ready[grant_q] = 1'b1;
                    tx_ch_d    = port_if.req_ch[{grant_q, 3'b000} +: 8];
                    tx_valid_d = 1'b1;
                    gap_d      = GAP_INIT;
                    tmo_d      = '0;
                    state_d    = GAP;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        if (rst_i) req_ready = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            tx_ch_q    <= '0;
            gap_q      <= '0;
            tx_valid_q <= 1'b0;
`ifdef EMU_UART_LINE_LOCK_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            tx_ch_q    <= tx_ch_d;
            gap_q      <= gap_d;
            tx_valid_q <= tx_valid_d;
`ifdef EMU_UART_LINE_LOCK_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    // RX FIFO: a pop in the same cycle frees the slot, so full+push+pop is not an overflow.
    logic [7:0]    mem_q [RX_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic          full, push, pop;

    assign full = (cnt_q == CW'(RX_DEPTH));
    assign pop  = (cnt_q != '0) && port_if.rxq_ready;
    assign push = port_if.rx_valid && (!full || pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
            if (port_if.rx_valid && !push) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= port_if.rx_ch;
    end

    assign port_if.req_ready   = req_ready;
    assign port_if.grant_id    = grant_q;
    assign port_if.tx_valid    = tx_valid_q;
    assign port_if.tx_ch       = tx_ch_q;
    assign port_if.rxq_valid   = (cnt_q != '0);
    assign port_if.rxq_ch      = (cnt_q != '0) ? mem_q[rd_q] : 8'h00;
    assign port_if.rx_overflow = ovf_q;
endmodule
